// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner on the KCPSM6 port bus.
// Firmware programs digits and control once; anodes are then time-multiplexed with blanking.
module sevenseg_scan_ctrl #(
  parameter logic [7:0] BASE_ADDR    = 8'h20,
  parameter int         TICK_BASE    = 1024,
  parameter int         BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  output logic [7:0] rd_data,
  output logic [7:0] seg,
  output logic [3:0] an
);

  localparam int BASE_W = $clog2(TICK_BASE);
  localparam logic [BASE_W-1:0] BASE_LAST  = BASE_W'(TICK_BASE - 1);
  localparam logic [BASE_W-1:0] BLANK_LAST = BASE_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  logic [7:0]        r_dig [4];
  logic [7:0]        r_ctrl;
  logic [7:0]        r_div;
  logic [7:0]        r_frame;
  logic [1:0]        r_idx;
  logic [1:0]        r_state;
  logic [BASE_W-1:0] r_base_cnt;
  logic [7:0]        r_slot_cnt;
  logic [7:0]        r_seg;
  logic [3:0]        r_an;
  logic [7:0]        r_rd_data;

  logic [7:0]        w_off;
  logic              w_hit;
  logic              w_wr;
  logic              w_en;
  logic              w_hex;
  logic [3:0]        w_mask;
  logic              w_base_term;
  logic              w_slot_term;
  logic [1:0]        w_state_nxt;
  logic [1:0]        w_idx_nxt;
  logic [BASE_W-1:0] w_base_nxt;
  logic [7:0]        w_slot_nxt;
  logic              w_frame_inc;
  logic [7:0]        w_pat;
  logic [7:0]        w_rd_nxt;

  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    case (v)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h08;
      4'hB:    return 7'h03;
      4'hC:    return 7'h46;
      4'hD:    return 7'h21;
      4'hE:    return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // Modulo-256 offset also covers a register window that wraps past 8'hFF.
  assign w_off  = port_id - BASE_ADDR;
  assign w_hit  = (w_off < 8'd8);
  assign w_wr   = write_strobe && w_hit;
  assign w_en   = r_ctrl[0];
  assign w_hex  = r_ctrl[1];
  assign w_mask = r_ctrl[7:4];

  // >= so a DIV lowered below the running slot count ends the slot instead of wrapping.
  assign w_base_term = (r_base_cnt >= BASE_LAST);
  assign w_slot_term = (r_slot_cnt >= r_div);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_base_nxt  = r_base_cnt;
    w_slot_nxt  = r_slot_cnt;
    w_frame_inc = 1'b0;
    if (!w_en) begin
      w_state_nxt = ST_OFF;
      w_idx_nxt   = 2'd0;
      w_base_nxt  = '0;
      w_slot_nxt  = 8'd0;
    end else if (r_state != ST_BLANK && r_state != ST_DRIVE) begin
      w_state_nxt = ST_BLANK;
    end else if (w_base_term && w_slot_term) begin
      w_state_nxt = ST_BLANK;
      w_idx_nxt   = r_idx + 2'd1;
      w_base_nxt  = '0;
      w_slot_nxt  = 8'd0;
      w_frame_inc = (r_idx == 2'd3);
    end else begin
      if (w_base_term) begin
        w_base_nxt = '0;
        w_slot_nxt = r_slot_cnt + 8'd1;
      end else begin
        w_base_nxt = r_base_cnt + BASE_W'(1);
      end
      if (r_state == ST_BLANK && r_base_cnt >= BLANK_LAST) begin
        w_state_nxt = ST_DRIVE;
      end
    end
  end

  assign w_pat = w_hex ? {~r_dig[w_idx_nxt][4], hex_decode(r_dig[w_idx_nxt][3:0])}
                       : r_dig[w_idx_nxt];

  always_comb begin
    w_rd_nxt = 8'h00;
    if (w_hit) begin
      case (w_off[2:0])
        3'd4:    w_rd_nxt = r_ctrl;
        3'd5:    w_rd_nxt = r_div;
        3'd6:    w_rd_nxt = r_frame;
        3'd7:    w_rd_nxt = {4'b0000, w_en, w_hex, r_idx};
        default: w_rd_nxt = r_dig[w_off[1:0]];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the digit array is four small flop registers, not a RAM, so it is reset like the rest.
      for (int i = 0; i < 4; i++) r_dig[i] <= 8'h00;
      r_ctrl     <= 8'h00;
      r_div      <= 8'h00;
      r_frame    <= 8'h00;
      r_idx      <= 2'd0;
      r_state    <= ST_OFF;
      r_base_cnt <= '0;
      r_slot_cnt <= 8'd0;
      r_seg      <= 8'hFF;
      r_an       <= 4'hF;
      r_rd_data  <= 8'h00;
    end else begin
      if (w_wr) begin
        case (w_off[2:0])
          3'd0, 3'd1, 3'd2, 3'd3: r_dig[w_off[1:0]] <= out_port;
          3'd4:                   r_ctrl            <= out_port;
          3'd5:                   r_div             <= out_port;
          default:                ;
        endcase
      end
      if (w_frame_inc) r_frame <= r_frame + 8'd1;
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_base_cnt <= w_base_nxt;
      r_slot_cnt <= w_slot_nxt;
      r_rd_data  <= w_rd_nxt;
      // Outputs follow the next state so the anodes line up with the slot counters.
      if (w_state_nxt == ST_DRIVE) begin
        r_seg <= w_pat;
        r_an  <= w_mask[w_idx_nxt] ? ~(4'b0001 << w_idx_nxt) : 4'hF;
      end else begin
        r_seg <= 8'hFF;
        r_an  <= 4'hF;
      end
    end
  end

  assign rd_data = r_rd_data;
  assign seg     = r_seg;
  assign an      = r_an;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with TICK_BASE=4 and BLANK_CYCLES=1.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_sevenseg_scan_ctrl;

  localparam logic [7:0] B = 8'h20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic [7:0] rd_data;
  logic [7:0] seg;
  logic [3:0] an;

  int n_total = 0;
  int n_bad   = 0;

  sevenseg_scan_ctrl #(
    .BASE_ADDR   (B),
    .TICK_BASE   (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .port_id     (port_id),
    .out_port    (out_port),
    .write_strobe(write_strobe),
    .rd_data     (rd_data),
    .seg         (seg),
    .an          (an)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] expv, input string tag);
    port_id = a;
    tick();
    check(tag, rd_data, expv);
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget, input string tag);
    int n = 0;
    while (an !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, {4'h0, an}, {4'h0, target});
  endtask

  // Walk n cycles from in-slot phase p0 of digit s0; shown digits drive their pattern after one blank cycle.
  task automatic scan_check(input logic [3:0] mask, input logic [31:0] segs,
                            input int s0, input int p0, input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      int p = (p0 + k) % 4;
      int s = (s0 + (p0 + k) / 4) % 4;
      logic [3:0] exp_an;
      exp_an = (p != 0 && mask[s]) ? ~(4'b0001 << s) : 4'hF;
      check({tag, "_an"}, {4'h0, an}, {4'h0, exp_an});
      if (p == 0) check({tag, "_blank_seg"}, seg, 8'hFF);
      else if (mask[s]) check({tag, "_seg"}, seg, segs[s*8 +: 8]);
      tick();
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    port_id      = 8'h00;
    out_port     = 8'h00;
    write_strobe = 1'b0;
    repeat (3) tick();
    check("rst_seg", seg, 8'hFF);
    check("rst_an", {4'h0, an}, 8'h0F);
    check("rst_rd", rd_data, 8'h00);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(B + 8'(i), 8'h00, "rst_reg");
      check("rst_hold_an", {4'h0, an}, 8'h0F);
      check("rst_hold_seg", seg, 8'hFF);
    end

    // Program digits, then check readback, read-only offsets and unmapped addresses.
    wr(B + 8'd0, 8'h01);
    wr(B + 8'd1, 8'h02);
    wr(B + 8'd2, 8'h03);
    wr(B + 8'd3, 8'h04);
    wr(B + 8'd5, 8'h00);
    wr(B + 8'd6, 8'h55);
    wr(B + 8'd7, 8'hAA);
    rd(B + 8'd0, 8'h01, "dig0_rd");
    rd(B + 8'd3, 8'h04, "dig3_rd");
    rd(B + 8'd6, 8'h00, "frame_ro");
    rd(B + 8'd7, 8'h00, "stat_ro");
    rd(8'h28, 8'h00, "unmapped_hi");
    rd(8'h1F, 8'h00, "unmapped_lo");
    check("disabled_an", {4'h0, an}, 8'h0F);

    // Hex decode, all digits shown, DIV=0: 4-cycle slots.
    wr(B + 8'd4, 8'hF3);
    wait_an(4'hE, 20, "hex_sync");
    scan_check(4'hF, {8'h99, 8'hB0, 8'hA4, 8'hF9}, 0, 1, 32, "hex");

    // Raw mode, MASK=0101: only digits 0 and 2 light, slot timing unchanged.
    wr(B + 8'd4, 8'h51);
    wr(B + 8'd1, 8'h00);
    wait_an(4'hB, 40, "mask_sync_b");
    wait_an(4'hE, 40, "mask_sync_e");
    scan_check(4'h5, {8'h04, 8'h03, 8'h00, 8'h01}, 0, 1, 32, "mask");

    // DIV=3 gives 16-cycle slots; dropping DIV to 0 at slot count 2, base 3 ends the slot next edge.
    wr(B + 8'd5, 8'h03);
    wait_an(4'hB, 80, "div_sync_b");
    wait_an(4'hE, 80, "div_sync_e");
    for (int t = 0; t < 10; t++) begin
      check("div3_hold", {4'h0, an}, 8'h0E);
      if (t < 9) tick();
    end
    wr(B + 8'd5, 8'h00);
    check("div_last_drive", {4'h0, an}, 8'h0E);
    tick();
    scan_check(4'h5, {8'h04, 8'h03, 8'h00, 8'h01}, 1, 0, 32, "div0");

    // Disable during digit 2 drive, then re-enable from digit 0.
    wait_an(4'hB, 40, "off_sync");
    wr(B + 8'd4, 8'h00);
    tick();
    check("off_an", {4'h0, an}, 8'h0F);
    check("off_seg", seg, 8'hFF);
    rd(B + 8'd7, 8'h00, "stat_off");
    rd(B + 8'd4, 8'h00, "ctrl_off");
    for (int i = 0; i < 6; i++) begin
      tick();
      check("off_hold_an", {4'h0, an}, 8'h0F);
    end
    wr(B + 8'd4, 8'hF3);
    begin
      int n = 0;
      while (an === 4'hF && n < 10) begin
        tick();
        n++;
      end
    end
    check("reen_an", {4'h0, an}, 8'h0E);
    check("reen_seg", seg, 8'hF9);

    // Mid-scan reset with a simultaneous write: reset wins and clears everything.
    reset_n      = 1'b0;
    port_id      = B;
    out_port     = 8'hAA;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    check("mrst_an", {4'h0, an}, 8'h0F);
    check("mrst_seg", seg, 8'hFF);
    check("mrst_rd", rd_data, 8'h00);
    reset_n = 1'b1;
    rd(B + 8'd0, 8'h00, "rst_dom_dig0");
    rd(B + 8'd4, 8'h00, "mrst_ctrl");
    rd(B + 8'd6, 8'h00, "mrst_frame");

    // FRAME: 256 frames of 16 cycles from the first digit-0 drive cycle.
    wr(B + 8'd4, 8'hF3);
    port_id = B + 8'd6;
    begin
      int n = 0;
      while (an === 4'hF && n < 10) begin
        tick();
        n++;
      end
    end
    check("frame_sync", {4'h0, an}, 8'h0E);
    repeat (4090) tick();
    check("frame_ff", rd_data, 8'hFF);
    repeat (10) tick();
    check("frame_wrap", rd_data, 8'h00);
    repeat (16) tick();
    check("frame_next", rd_data, 8'h01);

    // Final reset pulse while scanning.
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    check("end_rst_an", {4'h0, an}, 8'h0F);
    check("end_rst_seg", seg, 8'hFF);
    check("end_rst_rd", rd_data, 8'h00);
    tick();
    check("end_rst_hold_an", {4'h0, an}, 8'h0F);
    reset_n = 1'b1;
    rd(B + 8'd6, 8'h00, "end_rst_frame");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
